// File: rtl/fifo_rr_wr_arbiter.sv
// Round-robin write-side arbiter: NUM_REQ producers share one FIFO write port.
// A granted producer keeps the port for up to MAX_BURST beats so its beats land
// contiguously in the FIFO. Each written word is {source ID, payload}.
//
// Handshake: a beat moves when the selected requester has valid=1 and the FIFO
// is not full. In that same cycle req_ready_o[sel]=1 and fifo_wr_en_o=1. There
// is no buffering inside the arbiter. Requesters hold valid/data until ready.
module fifo_rr_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    localparam int IDW      = $clog2(NUM_REQ),
    localparam int CW       = $clog2(MAX_BURST + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    input  logic                     fifo_full_i,
    output logic                     fifo_wr_en_o,
    output logic [IDW+WIDTH-1:0]     fifo_wr_data_o,
    output logic [IDW-1:0]           grant_id_o,
    output logic                     busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [IDW-1:0]   last_ptr_q, last_ptr_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]    beat_cnt_inc;

    logic [IDW-1:0]   rr_sel;
    logic             rr_found;
    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   sel;
    logic             sel_valid;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;

    // Round-robin search: first valid requester after last_ptr, wrapping.
    always_comb begin
        rr_sel   = '0;
        rr_found = 1'b0;
        cand     = last_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (cand == IDW'(NUM_REQ - 1)) ? '0 : cand + IDW'(1);
            if (!rr_found && req_valid_i[cand]) begin
                rr_found = 1'b1;
                rr_sel   = cand;
            end
        end
    end

    // Pick the source for this cycle and decide whether a beat moves.
    always_comb begin
        sel       = (state_q == BURST) ? owner_q : rr_sel;
        sel_valid = (state_q == BURST) ? req_valid_i[owner_q] : rr_found;
        xfer      = rst_n && sel_valid && !fifo_full_i;
        sel_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == IDW'(i)) begin
                sel_data = req_data_i[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic for burst ownership and the round-robin pointer.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_ptr_d   = last_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        beat_cnt_inc = beat_cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (MAX_BURST == 1) begin
                        // Single-beat grants never enter BURST.
                        last_ptr_d = sel;
                    end else begin
                        state_d    = BURST;
                        owner_d    = sel;
                        beat_cnt_d = CW'(1);
                    end
                end
            end
            BURST: begin
                if (!req_valid_i[owner_q]) begin
                    // Owner ran dry: release now, arbitrate next cycle.
                    state_d    = IDLE;
                    last_ptr_d = owner_q;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    if (beat_cnt_inc == CW'(MAX_BURST)) begin
                        state_d    = IDLE;
                        last_ptr_d = owner_q;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_inc;
                    end
                end
                // FIFO full with owner valid: hold everything.
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write-port and ready outputs; all zero unless a beat moves.
    always_comb begin
        req_ready_o    = '0;
        fifo_wr_en_o   = xfer;
        fifo_wr_data_o = '0;
        if (xfer) begin
            req_ready_o[sel] = 1'b1;
            fifo_wr_data_o   = {sel, sel_data};
        end
    end

    assign grant_id_o = owner_q;
    assign busy_o     = (state_q == BURST);

    // State registers; last_ptr resets to the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            beat_cnt_q <= '0;
            last_ptr_q <= IDW'(NUM_REQ - 1);
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            last_ptr_q <= last_ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_rr_wr_arbiter.sv
// Bench for fifo_rr_wr_arbiter: a MAX_BURST=4 and a MAX_BURST=1 instance share
// the stimulus; one of them is observed at a time. Every cycle of a scenario has
// an expected entry {wr_en, busy, id, payload} queued when the stimulus is set up.
module tb_fifo_rr_wr_arbiter;

    localparam int NR  = 4;
    localparam int W   = 8;
    localparam int IDW = 2;
    localparam int EW  = IDW + W + 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid_i;
    logic [NR*W-1:0]   req_data_i;
    logic              fifo_full_i;

    logic [NR-1:0]     ready4, ready1;
    logic              wr_en4, wr_en1;
    logic [IDW+W-1:0]  wr_data4, wr_data1;
    logic [IDW-1:0]    grant4, grant1;
    logic              busy4, busy1;

    logic              use1;
    logic [NR-1:0]     m_ready;
    logic              m_wr_en;
    logic [IDW+W-1:0]  m_wr_data;
    logic [IDW-1:0]    m_grant;
    logic              m_busy;

    logic [NR-1:0]     en;
    logic [W-1:0]      pay[NR];
    logic [W-1:0]      exp_pay[NR];
    logic [EW-1:0]     exp_q[$];
    int                n_checks;
    int                n_errors;

    fifo_rr_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(ready4), .fifo_full_i(fifo_full_i), .fifo_wr_en_o(wr_en4),
        .fifo_wr_data_o(wr_data4), .grant_id_o(grant4), .busy_o(busy4)
    );

    fifo_rr_wr_arbiter #(.NUM_REQ(NR), .WIDTH(W), .MAX_BURST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_ready_o(ready1), .fifo_full_i(fifo_full_i), .fifo_wr_en_o(wr_en1),
        .fifo_wr_data_o(wr_data1), .grant_id_o(grant1), .busy_o(busy1)
    );

    // Clock
    always #5 clk = ~clk;

    // Observed-instance mux
    always_comb begin
        m_ready   = use1 ? ready1   : ready4;
        m_wr_en   = use1 ? wr_en1   : wr_en4;
        m_wr_data = use1 ? wr_data1 : wr_data4;
        m_grant   = use1 ? grant1   : grant4;
        m_busy    = use1 ? busy1    : busy4;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic init_src(input int id, input logic [W-1:0] base);
        pay[id]     = base;
        exp_pay[id] = base;
    endtask

    task automatic push_beat(input int id, input logic busy);
        exp_q.push_back({1'b1, busy, IDW'(id), exp_pay[id]});
        exp_pay[id] = exp_pay[id] + 1'b1;
    endtask

    task automatic push_idle(input logic busy);
        exp_q.push_back({1'b0, busy, {(IDW+W){1'b0}}});
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid_i[i]         = en[i];
            req_data_i[i*W +: W]   = pay[i];
        end
    endtask

    // Scoreboard: compare the observed instance against the next expected cycle.
    task automatic monitor();
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_en", m_wr_en, e[EW-1]);
            check("busy", m_busy, e[EW-2]);
            if (e[EW-1]) begin
                check("wr_data", m_wr_data, e[IDW+W-1:0]);
                check("ready", m_ready, 32'(1) << e[IDW+W-1:W]);
                if (e[EW-2]) check("grant_id", m_grant, e[IDW+W-1:W]);
            end else begin
                check("wr_data_idle", m_wr_data, 0);
                check("ready_idle", m_ready, 0);
            end
        end
    endtask

    task automatic tick();
        logic [NR-1:0] acc;
        @(negedge clk);
        monitor();
        acc = m_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i]) pay[i] = pay[i] + 1'b1;
        end
        drive();
    endtask

    task automatic hard_reset();
        rst_n       = 1'b0;
        en          = '0;
        fifo_full_i = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic drain_check(input string tag);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        use1        = 1'b0;
        fifo_full_i = 1'b0;
        en          = '0;
        for (int i = 0; i < NR; i++) init_src(i, '0);

        // Reset with only req 2 valid; outputs must be zero until release.
        rst_n = 1'b0;
        en[2] = 1'b1;
        init_src(2, 8'hA5);
        drive();
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", wr_en4, 0);
        check("rst_ready", ready4, 0);
        check("rst_wr_data", wr_data4, 0);
        check("rst_grant", grant4, 0);
        check("rst_busy", busy4, 0);
        rst_n = 1'b1;
        push_beat(2, 1'b0);
        push_idle(1'b1);
        push_idle(1'b0);
        tick();
        en[2] = 1'b0;
        drive();
        tick();
        tick();
        drain_check("t1_drain");

        // All four requesters continuously valid: bursts of four in RR order.
        hard_reset();
        for (int i = 0; i < NR; i++) init_src(i, W'(i * 16 + 3));
        en = '1;
        drive();
        for (int b = 0; b < 17; b++) push_beat((b / 4) % NR, (b % 4) != 0);
        repeat (17) tick();
        drain_check("t2_drain");

        // FIFO full for three cycles after req 1's second beat.
        hard_reset();
        init_src(1, 8'h40);
        init_src(2, 8'h80);
        en[1] = 1'b1;
        en[2] = 1'b1;
        drive();
        push_beat(1, 1'b0);
        push_beat(1, 1'b1);
        repeat (3) push_idle(1'b1);
        push_beat(1, 1'b1);
        push_beat(1, 1'b1);
        push_beat(2, 1'b0);
        push_beat(2, 1'b1);
        tick();
        tick();
        fifo_full_i = 1'b1;
        repeat (3) tick();
        fifo_full_i = 1'b0;
        repeat (4) tick();
        drain_check("t3_drain");

        // Req 0 drops after one beat: one bubble, then req 1, then req 3.
        hard_reset();
        init_src(0, 8'h10);
        init_src(1, 8'h20);
        init_src(3, 8'h30);
        en[0] = 1'b1;
        en[1] = 1'b1;
        en[3] = 1'b1;
        drive();
        push_beat(0, 1'b0);
        push_idle(1'b1);
        push_beat(1, 1'b0);
        repeat (3) push_beat(1, 1'b1);
        push_beat(3, 1'b0);
        repeat (3) push_beat(3, 1'b1);
        push_beat(1, 1'b0);
        tick();
        en[0] = 1'b0;
        drive();
        repeat (10) tick();
        drain_check("t4_drain");

        // Single-beat grants: reqs 0 and 3 alternate with no bubbles.
        hard_reset();
        use1 = 1'b1;
        init_src(0, 8'h50);
        init_src(3, 8'hE0);
        en[0] = 1'b1;
        en[3] = 1'b1;
        drive();
        for (int b = 0; b < 6; b++) push_beat((b % 2 == 0) ? 0 : 3, 1'b0);
        repeat (6) tick();
        drain_check("t5_drain");
        use1 = 1'b0;

        // Reset pulsed during req 2's third beat.
        hard_reset();
        init_src(2, 8'hC0);
        en[2] = 1'b1;
        drive();
        push_beat(2, 1'b0);
        push_beat(2, 1'b1);
        tick();
        tick();
        #2;
        check("t6_beat3_wr_en", wr_en4, 1);
        check("t6_beat3_data", wr_data4, {2'd2, exp_pay[2]});
        rst_n = 1'b0;
        #1;
        check("t6_rst_wr_en", wr_en4, 0);
        check("t6_rst_ready", ready4, 0);
        check("t6_rst_wr_data", wr_data4, 0);
        check("t6_rst_busy", busy4, 0);
        check("t6_rst_grant", grant4, 0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) init_src(i, W'(8'h60 + i * 8));
        en = '1;
        drive();
        rst_n = 1'b1;
        push_beat(0, 1'b0);
        repeat (3) push_beat(0, 1'b1);
        push_beat(1, 1'b0);
        repeat (5) tick();
        drain_check("t6_drain");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_rr_wr_arbiter.md
Name: fifo_rr_wr_arbiter

Overview:
Round-robin write-side arbiter that shares one synchronous FIFO between NUM_REQ producers. Each producer offers beats over a valid/ready handshake. The arbiter selects one producer and drives the FIFO write port, prefixing each beat with the source ID. A granted producer keeps the port for a burst of up to MAX_BURST beats, which keeps bursts contiguous in the FIFO.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
WIDTH, 8, payload width per beat
MAX_BURST, 4, maximum beats per grant (>=1)
IDW (localparam), $clog2(NUM_REQ), source ID width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid_i  in  NUM_REQ  per-requester beat valid
req_data_i  in  NUM_REQ*WIDTH  payloads; requester i occupies bits [i*WIDTH +: WIDTH]
req_ready_o  out  NUM_REQ  per-requester beat accepted this cycle (one-hot or zero)
fifo_full_i  in  1  FIFO full flag
fifo_wr_en_o  out  1  FIFO write enable
fifo_wr_data_o  out  IDW+WIDTH  {source ID, payload}
grant_id_o  out  IDW  current owner ID; valid while busy_o=1
busy_o  out  1  a burst is in progress (state BURST)

Behaviour:
- Registered state: fsm (IDLE/BURST), owner[IDW], beat_cnt (counts 0..MAX_BURST), last_ptr[IDW].
- Reset values: fsm=IDLE, owner=0, beat_cnt=0, last_ptr=NUM_REQ-1, so requester 0 has first priority.
- While rst_n=0: req_ready_o=0, fifo_wr_en_o=0, fifo_wr_data_o=0, grant_id_o=0, busy_o=0.
- Handshake is zero-latency and combinational:
  - A transfer occurs when the selected requester is valid and fifo_full_i=0.
  - In a transfer cycle, fifo_wr_en_o=1 and req_ready_o[sel]=1 in the same cycle.
  - fifo_wr_data_o={sel, req_data_i[sel]}.
  - No transfer ever occurs while fifo_full_i=1.
  - fifo_wr_data_o=0 when fifo_wr_en_o=0.
- IDLE:
  - sel = first valid requester searching last_ptr+1, last_ptr+2, ... modulo NUM_REQ.
  - If no requester is valid, or fifo_full_i=1: no transfer, no state change.
  - On a transfer with MAX_BURST=1: stay in IDLE, last_ptr<=sel.
  - On a transfer with MAX_BURST>1: go to BURST, owner<=sel, beat_cnt<=1.
- BURST:
  - sel=owner. Other requesters are never ready.
  - On a transfer: beat_cnt increments. If the new count equals MAX_BURST: go to IDLE, last_ptr<=owner, beat_cnt<=0.
  - Owner valid=0: no transfer; go to IDLE, last_ptr<=owner, beat_cnt<=0. This leaves one bubble cycle; the next arbitration happens in IDLE on the following cycle.
  - fifo_full_i=1 with owner valid: stall. State, beat_cnt and ownership are held, and stall cycles do not count toward MAX_BURST.
- Fairness: the just-served requester has lowest priority in the next arbitration. Under continuous demand, every valid requester waits at most (NUM_REQ-1)*MAX_BURST transfer beats.
- Reset asserted mid-burst: state clears immediately. The partial burst is abandoned, and beats already written remain in the FIFO.
- Requesters must hold valid and data stable until ready. The arbiter never drops or duplicates an accepted beat.

Test Plan:
- Reset release, only req 2 valid with data 0xA5, full=0 -> same cycle: wr_en=1, ready=4'b0100, wr_data={2'd2,8'hA5}. Before release, all outputs are 0.
- All 4 valid continuously, full=0, MAX_BURST=4 -> source ID sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0. busy_o=1 during beats 2-4 of each burst.
- Req 1 owns a burst; full=1 for 3 cycles after its 2nd beat -> wr_en=0 and ready=0 for those cycles. Req 1 then completes beats 3-4, followed by req 2.
- Req 0 drops valid after 1 beat while reqs 1 and 3 are valid -> one cycle with wr_en=0, then req 1 is granted; req 3 follows after req 1's burst.
- MAX_BURST=1, reqs 0 and 3 valid continuously -> ID sequence 0,3,0,3 with no bubbles and busy_o=0 throughout.
- rst_n pulsed low during req 2's 3rd beat -> outputs go to 0 asynchronously. After release with all valid, req 0 is granted first.
